// File: rtl/qnigma_poly1305_pkg.sv
// Shared types, constants and helpers for the qnigma Poly1305 AEAD engine.
package qnigma_poly1305_pkg;

  localparam int P1305_BLK_BYTES = 16;
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef logic [127:0] poly_tag_t;
  typedef logic [128:0] poly_blk_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ADD,
    S_MUL,
    S_PAD,
    S_LEN,
    S_FINAL
  } poly_state_t;

  // Port byte order (byte 0 in the MSBs) <-> little-endian integer.
  function automatic logic [127:0] byte_swap128(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
    return o;
  endfunction

endpackage

// File: rtl/qnigma_poly1305_blkbuf.sv
// 16-byte little-endian block assembler; unwritten slots read as zero, so
// padding is free and only the 2^128 / 2^(8*idx) marker needs inserting.
module qnigma_poly1305_blkbuf
  import qnigma_poly1305_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       full_pad,
  output logic [4:0] idx,
  output logic       lst,
  output poly_blk_t  blk
);

  logic [127:0] buf_q, buf_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   mark_pos;

  always_comb begin
    buf_d = clr ? '0 : buf_q;
    idx_d = clr ? '0 : idx_q;
    if (wr) begin
      buf_d[{idx_d[3:0], 3'b000} +: 8] = din;
      idx_d = idx_d + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  assign idx      = idx_q;
  assign lst      = wr && !clr && (idx_q == 5'(P1305_BLK_BYTES - 1));
  assign mark_pos = (full_pad || idx_q[4]) ? 8'd128 : {1'b0, idx_q[3:0], 3'b000};
  assign blk      = {1'b0, buf_q} | (poly_blk_t'(1) << mark_pos);

endmodule

// File: rtl/qnigma_poly1305_aead.sv
// Poly1305 MAC engine with RFC8439 AEAD padding/length block; field math via
// the shared ALU. Optional tag compare: define QNIGMA_POLY1305_VERIFY_EN.
// state   | meaning
// COLLECT | assembling bytes;  PAD | close a zero-padded block
// ADD/MUL | acc=(acc+n)*r via ALU;  LEN | AEAD length block;  FINAL | tag out
module qnigma_poly1305_aead
  import qnigma_poly1305_pkg::*;
#(
  parameter int W     = 256,
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     din,
  input  logic           vin,
  input  logic           sof,
  input  logic           eof,
  input  logic           sel,
  input  logic           aead,
  output logic           cts,
  output logic           lst,
  input  logic [255:0]   key,
  output logic [W-1:0]   alu_opa,
  output logic [W-1:0]   alu_opb,
  output logic           alu_add,
  output logic           alu_mul,
  output logic           alu_cal,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_rdy,
  output logic [127:0]   tag,
  output logic           tag_val,
`ifdef QNIGMA_POLY1305_VERIFY_EN
  input  logic [127:0]   tag_ref,
  output logic           tag_ok,
`endif
  output logic           err
);

  poly_state_t      state_q, state_d;
  logic             aead_q, in_ct_q, done_q, len_ph_q, issued_q;
  logic [127:0]     r_q, s_q;
  logic [W-1:0]     acc_q;
  logic [LEN_W-1:0] aad_len_q, ct_len_q;
  logic             wr, clr, hold, bad_sw, rdy_ok;
  logic [4:0]       idx;
  poly_blk_t        buf_blk, len_blk, cur_blk;
  poly_tag_t        tag_sum;

  qnigma_poly1305_blkbuf u_blkbuf (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr       (wr),
    .din      (din),
    .full_pad (aead_q),
    .idx      (idx),
    .lst      (lst),
    .blk      (buf_blk)
  );

  // First CT byte behind a partial AAD block waits until that block is padded out.
  assign hold    = aead_q && vin && !sof && sel && !in_ct_q && (idx != 5'd0);
  assign bad_sw  = aead_q && !sel && in_ct_q;
  assign rdy_ok  = alu_rdy && issued_q;
  assign len_blk = {1'b1, 64'(ct_len_q), 64'(aad_len_q)};
  assign cur_blk = len_ph_q ? len_blk : buf_blk;
  assign tag_sum = acc_q[127:0] + s_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (vin && sof) state_d = S_COLLECT;
      S_COLLECT: begin
        if (done_q || hold) state_d = aead_q ? S_PAD : S_ADD;
        else if (lst)       state_d = S_ADD;
      end
      S_PAD:     state_d = S_ADD;
      S_LEN:     state_d = S_ADD;
      S_ADD:     if (rdy_ok) state_d = S_MUL;
      S_MUL: begin
        if (rdy_ok) begin
          if (!done_q)                  state_d = S_COLLECT;
          else if (aead_q && !len_ph_q) state_d = S_LEN;
          else                          state_d = S_FINAL;
        end
      end
      S_FINAL:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cts     = 1'b0;
    wr      = 1'b0;
    clr     = 1'b0;
    alu_cal = 1'b0;
    alu_add = 1'b0;
    alu_mul = 1'b0;
    alu_opa = '0;
    alu_opb = '0;
    case (state_q)
      S_IDLE: begin
        cts = !rst;
        wr  = vin && sof;
        clr = vin && sof;
      end
      S_COLLECT: begin
        cts = !done_q && !hold;
        wr  = cts && vin && !sof && !bad_sw;
      end
      S_ADD: begin
        alu_add = 1'b1;
        alu_cal = !issued_q;
        alu_opa = acc_q;
        alu_opb = W'(cur_blk);
      end
      S_MUL: begin
        alu_mul = 1'b1;
        alu_cal = !issued_q;
        alu_opa = acc_q;
        alu_opb = W'(r_q);
        clr     = rdy_ok && !done_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aead_q    <= 1'b0;
      in_ct_q   <= 1'b0;
      done_q    <= 1'b0;
      len_ph_q  <= 1'b0;
      issued_q  <= 1'b0;
      r_q       <= '0;
      s_q       <= '0;
      acc_q     <= '0;
      aad_len_q <= '0;
      ct_len_q  <= '0;
      tag       <= '0;
      tag_val   <= 1'b0;
      err       <= 1'b0;
`ifdef QNIGMA_POLY1305_VERIFY_EN
      tag_ok    <= 1'b0;
`endif
    end else begin
      issued_q <= (state_d == state_q) ? (issued_q | alu_cal) : 1'b0;
      tag_val  <= 1'b0;
      if (state_q == S_IDLE && vin) begin
        if (sof) begin
          aead_q    <= aead;
          r_q       <= byte_swap128(key[255:128]) & R_CLAMP;
          s_q       <= byte_swap128(key[127:0]);
          acc_q     <= '0;
          aad_len_q <= LEN_W'(aead && !sel);
          ct_len_q  <= LEN_W'(aead && sel);
          in_ct_q   <= aead && sel;
          done_q    <= eof;
          len_ph_q  <= 1'b0;
          err       <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state_q != S_IDLE && vin && sof) err <= 1'b1;
      if (state_q == S_COLLECT && cts && vin && !sof && bad_sw) err <= 1'b1;
      if (state_q == S_COLLECT && wr) begin
        done_q <= eof;
        if (aead_q) begin
          if (sel) begin
            ct_len_q <= ct_len_q + LEN_W'(1);
            in_ct_q  <= 1'b1;
          end else begin
            aad_len_q <= aad_len_q + LEN_W'(1);
          end
        end
      end
      if ((state_q == S_ADD || state_q == S_MUL) && rdy_ok) acc_q <= alu_res;
      if (state_q == S_LEN) len_ph_q <= 1'b1;
      if (state_q == S_FINAL) begin
        tag     <= byte_swap128(tag_sum);
        tag_val <= 1'b1;
`ifdef QNIGMA_POLY1305_VERIFY_EN
        tag_ok  <= (byte_swap128(tag_sum) == tag_ref);
`endif
      end
    end
  end

endmodule

// File: tb/tb_qnigma_poly1305_aead.sv
// Bench for qnigma_poly1305_aead: F1305 ALU model plus an arithmetic Poly1305/AEAD reference.
module tb_qnigma_poly1305_aead;

  localparam int W = 256;
  localparam logic [263:0] P1305 = (264'd1 << 130) - 264'd5;
  localparam logic [255:0] K1 = 256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b;
  localparam logic [255:0] K2 = 256'h7bac2b252db447af09b67a55a4e955840ae1d6731075d9eb2a9375783ed553ff;
  localparam logic [127:0] T1 = 128'ha8061dc1305136c6c22b8baf0c0127a9;
  localparam logic [127:0] T2 = 128'h1ae10b594f09e26a7e902ecbd0600691;

  logic clk = 0, rst = 1;
  logic [7:0] din = 0;
  logic vin = 0, sof = 0, eof = 0, sel = 0, aead = 0;
  logic cts, lst;
  logic [255:0] key = 0;
  logic [W-1:0] alu_opa, alu_opb;
  logic alu_add, alu_mul, alu_cal;
  logic [W-1:0] alu_res = 0;
  logic alu_rdy = 0;
  logic [127:0] tag;
  logic tag_val, err;
`ifdef QNIGMA_POLY1305_VERIFY_EN
  logic [127:0] tag_ref = 0;
  logic tag_ok;
`endif

  int n_assert = 0, n_fail = 0;
  int cal_cnt = 0, tv_cnt = 0, lst_cnt = 0, pend_cnt = 0;
  logic [263:0] pend_res = 0, alu_a, alu_b;
  logic [7:0] m_byte[$];
  bit m_sel[$];
  bit gaps = 0;

  qnigma_poly1305_aead #(.W(W), .LEN_W(64)) dut (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .sof(sof), .eof(eof), .sel(sel),
    .aead(aead), .cts(cts), .lst(lst), .key(key),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_add(alu_add), .alu_mul(alu_mul),
    .alu_cal(alu_cal), .alu_res(alu_res), .alu_rdy(alu_rdy),
    .tag(tag), .tag_val(tag_val),
`ifdef QNIGMA_POLY1305_VERIFY_EN
    .tag_ref(tag_ref), .tag_ok(tag_ok),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // F1305 ALU with 1..3 cycle latency; deliberately ignores rst.
  assign alu_a = 264'(alu_opa);
  assign alu_b = 264'(alu_opb);
  always @(posedge clk) begin
    alu_rdy <= 1'b0;
    if (alu_cal) begin
      cal_cnt  <= cal_cnt + 1;
      pend_res <= alu_mul ? (alu_a * alu_b) % P1305 : (alu_a + alu_b) % P1305;
      pend_cnt <= $urandom_range(1, 3);
    end else if (pend_cnt != 0) begin
      if (pend_cnt == 1) begin
        alu_rdy <= 1'b1;
        alu_res <= pend_res[W-1:0];
      end
      pend_cnt <= pend_cnt - 1;
    end
    if (tag_val) tv_cnt <= tv_cnt + 1;
    if (vin && cts && lst) lst_cnt <= lst_cnt + 1;
  end

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [263:0] absorb(input logic [263:0] acc_in, input logic [263:0] r,
                                          input int first, input int cnt, input bit pad);
    logic [263:0] acc, n;
    int k;
    acc = acc_in;
    for (int b = 0; b < cnt; b += 16) begin
      k = (cnt - b < 16) ? cnt - b : 16;
      n = 0;
      for (int j = 0; j < k; j++) n[8*j +: 8] = m_byte[first+b+j];
      n[pad ? 128 : 8*k] = 1'b1;
      acc = ((acc + n) * r) % P1305;
    end
    return acc;
  endfunction

  function automatic logic [127:0] ref_tag(input logic [255:0] k, input bit md);
    logic [263:0] r, s, acc;
    logic [127:0] t, o;
    int na, nc;
    r = 0; s = 0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = k[255-8*i -: 8];
      s[8*i +: 8] = k[127-8*i -: 8];
    end
    r[127:0] = r[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    acc = 0;
    if (!md) begin
      acc = absorb(acc, r, 0, m_byte.size(), 1'b0);
    end else begin
      na = 0;
      foreach (m_sel[i]) if (!m_sel[i]) na++;
      nc = m_byte.size() - na;
      acc = absorb(acc, r, 0, na, 1'b1);
      acc = absorb(acc, r, na, nc, 1'b1);
      acc = ((acc + ((264'd1 << 128) | (264'(nc) << 64) | 264'(na))) * r) % P1305;
    end
    t = acc[127:0] + s[127:0];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[8*i +: 8];
    return o;
  endfunction

  task automatic load_str(input string s_in);
    m_byte.delete(); m_sel.delete();
    for (int i = 0; i < s_in.len(); i++) begin
      m_byte.push_back(s_in[i]);
      m_sel.push_back(1'b0);
    end
  endtask

  task automatic load_hex(input logic [1023:0] v, input int nb, input bit s);
    for (int i = 0; i < nb; i++) begin
      m_byte.push_back(v[8*(nb-1-i) +: 8]);
      m_sel.push_back(s);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit s, input bit so, input bit eo);
    bit ok;
    ok = 0;
    if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    din = b; sel = s; sof = so; eof = eo; vin = 1;
    for (int c = 0; c < 400 && !ok; c++) begin
      #1;
      if (cts) ok = 1;
      @(negedge clk);
    end
    vin = 0; sof = 0; eof = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic run_msg(input string nm, input logic [255:0] k, input bit md, input int inject);
    logic [127:0] exp;
    int tv0, lst0, exp_lst, na;
    bit got;
    exp = ref_tag(k, md);
    na = 0;
    foreach (m_sel[i]) if (md && !m_sel[i]) na++;
    exp_lst = na / 16 + (m_byte.size() - na) / 16;
    key = k; aead = md;
    tv0 = tv_cnt; lst0 = lst_cnt;
    foreach (m_byte[i]) begin
      if (i == inject) send_byte(8'h55, 1'b0, 1'b1, 1'b0);
      send_byte(m_byte[i], m_sel[i], i == 0, i == m_byte.size() - 1);
    end
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (tag_val) got = 1;
    end
    chk({nm, "_done"}, got, 1);
    if (got) chk({nm, "_tag"}, tag, exp);
    repeat (4) @(negedge clk);
    chk({nm, "_pulses"}, tv_cnt - tv0, 1);
    chk({nm, "_lst"}, lst_cnt - lst0, exp_lst);
  endtask

  task automatic load_rfc_aead();
    m_byte.delete(); m_sel.delete();
    load_hex(96'h50515253c0c1c2c3c4c5c6c7, 12, 1'b0);
    load_hex(912'hd31a8d34648e60db7b86afbc53ef7ec2_a4aded51296e08fea9e2b5a736ee62d6_3dbea45e8ca9671282fafb69da92728b_1a71de0a9e060b2905d6a5b67ecd3b36_92ddbd7f2d778b8c9803aee328091b58_fab324e4fad675945585808b4831d7bc_3ff4def08e4b7a9de576d26586cec64b_6116,
             114, 1'b1);
  endtask

  initial begin
    int cal0, tv0, na, nc;
    bit got;
    logic [255:0] k;
    string msg1;
    msg1 = "Cryptographic Forum Research Group";

    repeat (3) @(negedge clk);
    chk("reset_outs", {cts, lst, alu_cal, alu_add, alu_mul, tag_val, err}, 0);
    chk("reset_tag", tag, 0);
    rst = 0;
    @(negedge clk); #1;
    chk("idle_cts", cts, 1);

    load_str(msg1);
    run_msg("rfc_plain", K1, 1'b0, -1);
    chk("rfc_plain_const", tag, T1);
    chk("rfc_plain_err", err, 0);

    load_rfc_aead();
    run_msg("rfc_aead", K2, 1'b1, -1);
    chk("rfc_aead_const", tag, T2);
    chk("rfc_aead_err", err, 0);

    k = {128'h0, $urandom, $urandom, $urandom, $urandom};
    m_byte.delete(); m_sel.delete();
    for (int i = 0; i < 16; i++) begin m_byte.push_back(8'h00); m_sel.push_back(1'b0); end
    cal0 = cal_cnt;
    run_msg("zero_r", k, 1'b0, -1);
    chk("zero_r_is_s", tag, k[127:0]);
    chk("zero_r_cals", cal_cnt - cal0, 2);

    load_str(msg1);
    run_msg("stray_sof", K1, 1'b0, 10);
    chk("stray_sof_err", err, 1);
    chk("stray_sof_const", tag, T1);
    run_msg("after_err", K1, 1'b0, -1);
    chk("after_err_clr", err, 0);
    chk("after_err_const", tag, T1);

    key = K1; aead = 0;
    for (int i = 0; i < 16; i++) send_byte(m_byte[i], 1'b0, i == 0, 1'b0);
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (alu_mul) got = 1;
    end
    chk("rst_reach_mul", got, 1);
    tv0 = tv_cnt;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_mid_outs", {cts, lst, alu_cal, alu_add, alu_mul, tag_val, err}, 0);
    chk("rst_mid_tag", tag, 0);
    rst = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_no_tag", tv_cnt - tv0, 0);
    chk("rst_idle_cts", cts, 1);
    run_msg("after_rst", K1, 1'b0, -1);
    chk("after_rst_const", tag, T1);

`ifdef QNIGMA_POLY1305_VERIFY_EN
    load_rfc_aead();
    tag_ref = T2;
    run_msg("verify_ok", K2, 1'b1, -1);
    chk("verify_ok_flag", tag_ok, 1);
    tag_ref = T2 ^ 128'h1;
    run_msg("verify_bad", K2, 1'b1, -1);
    chk("verify_bad_flag", tag_ok, 0);
`endif

    gaps = 1;
    for (int it = 0; it < 10; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      m_byte.delete(); m_sel.delete();
      if (it % 2 == 0) begin
        nc = $urandom_range(1, 70);
        for (int i = 0; i < nc; i++) begin
          m_byte.push_back(8'($urandom)); m_sel.push_back(1'($urandom));
        end
        run_msg($sformatf("rnd_plain%0d", it), k, 1'b0, -1);
      end else begin
        na = $urandom_range(0, 40);
        nc = $urandom_range(0, 70);
        if (na + nc == 0) nc = 1;
        for (int i = 0; i < na; i++) begin m_byte.push_back(8'($urandom)); m_sel.push_back(1'b0); end
        for (int i = 0; i < nc; i++) begin m_byte.push_back(8'($urandom)); m_sel.push_back(1'b1); end
        run_msg($sformatf("rnd_aead%0d", it), k, 1'b1, -1);
      end
      chk($sformatf("rnd_err%0d", it), err, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
